// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-control bundle between the pipeline (master) and pc_fetch_unit (slave).
// History read signals exist only when PC_HIST_EN is defined.
interface pc_fetch_if #(
  parameter int AW = 32
`ifdef PC_HIST_EN
  , parameter int HIST_DEPTH = 8
`endif
);
  logic stall, redirect, exc, halt_req, resume;
  logic [AW-1:0] redirect_tgt, pc, pc_step;
  logic fetch_vld, misalign, halted;
`ifdef PC_HIST_EN
  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx;
  logic [AW-1:0] hist_rd_pc;
  modport master (
    output stall, redirect, redirect_tgt, exc, halt_req, resume, hist_rd_idx,
    input  pc, pc_step, fetch_vld, misalign, halted, hist_rd_pc
  );
  modport slave (
    input  stall, redirect, redirect_tgt, exc, halt_req, resume, hist_rd_idx,
    output pc, pc_step, fetch_vld, misalign, halted, hist_rd_pc
  );
`else
  modport master (
    output stall, redirect, redirect_tgt, exc, halt_req, resume,
    input  pc, pc_step, fetch_vld, misalign, halted
  );
  modport slave (
    input  stall, redirect, redirect_tgt, exc, halt_req, resume,
    output pc, pc_step, fetch_vld, misalign, halted
  );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencing (BOOT/RUN/HALT, redirect, exception, stall).
// Define PC_HIST_EN to add a circular history of fetched PCs with a combinational read port.
module pc_fetch_unit #(
  parameter int             AW         = 32,
  parameter int             STEP       = 4,
  parameter logic [AW-1:0]  RESET_VEC  = '0,
  parameter logic [31:0]    EXC_VEC    = 32'h0000_0080,
  parameter int             ALIGN_BITS = 2
`ifdef PC_HIST_EN
  , parameter int           HIST_DEPTH = 8
`endif
) (
  input logic        clkpc,
  input logic        rstpc_n,
  pc_fetch_if.slave  f
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [AW-1:0] EXC_PC = AW'(EXC_VEC);
  localparam logic [AW-1:0] AMASK  = AW'((64'd1 << ALIGN_BITS) - 64'd1);
  state_t state_q;
  logic [AW-1:0] pc_q, pc_d;
  logic mis_q, mis_d, bad_tgt, fetch;
  assign bad_tgt = |(f.redirect_tgt & AMASK);
  assign fetch = state_q == RUN && !f.stall;
  always_comb begin
    pc_d = pc_q;
    mis_d = 1'b0;
    if (state_q != BOOT) begin
      if (f.exc) pc_d = EXC_PC;
      else if (f.redirect) begin
        pc_d = bad_tgt ? EXC_PC : f.redirect_tgt;
        mis_d = bad_tgt;
      end else if (fetch) pc_d = pc_q + AW'(STEP);
    end
  end
  // halt_req only changes the state; the PC still advances on that edge
  always_ff @(posedge clkpc or negedge rstpc_n)
    if (!rstpc_n) begin
      state_q <= BOOT;
      pc_q <= RESET_VEC;
      mis_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      mis_q <= mis_d;
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= (!f.exc && f.halt_req) ? HALT : RUN;
        HALT:    state_q <= (f.exc || f.resume) ? RUN : HALT;
        default: state_q <= BOOT;
      endcase
    end
  assign f.pc = pc_q;
  assign f.pc_step = pc_q + AW'(STEP);
  assign f.fetch_vld = fetch;
  assign f.misalign = mis_q;
  assign f.halted = state_q == HALT;
`ifdef PC_HIST_EN
  localparam int HW = $clog2(HIST_DEPTH);
  logic [AW-1:0] hist_q [HIST_DEPTH];
  logic [HW-1:0] wr_ptr_q;
  always_ff @(posedge clkpc or negedge rstpc_n)
    if (!rstpc_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else if (fetch) begin
      hist_q[wr_ptr_q] <= pc_q;
      wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  assign f.hist_rd_pc = hist_q[wr_ptr_q - HW'(1) - f.hist_rd_idx];
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit against a cycle-level reference model.
module tb_pc_fetch_unit;
  localparam logic [31:0] EXC = 32'h80;
  logic clkpc = 1'b0, rstpc_n = 1'b0;
  always #5 clkpc = ~clkpc;
`ifdef PC_HIST_EN
  pc_fetch_if #(.AW(32), .HIST_DEPTH(4)) bus ();
  pc_fetch_if #(.AW(8), .HIST_DEPTH(4)) wbus ();
  pc_fetch_unit #(.HIST_DEPTH(4)) dut (.clkpc(clkpc), .rstpc_n(rstpc_n), .f(bus));
  pc_fetch_unit #(.AW(8), .RESET_VEC(8'hF8), .HIST_DEPTH(4)) wdut (.clkpc(clkpc), .rstpc_n(rstpc_n), .f(wbus));
`else
  pc_fetch_if #(.AW(32)) bus ();
  pc_fetch_if #(.AW(8)) wbus ();
  pc_fetch_unit dut (.clkpc(clkpc), .rstpc_n(rstpc_n), .f(bus));
  pc_fetch_unit #(.AW(8), .RESET_VEC(8'hF8)) wdut (.clkpc(clkpc), .rstpc_n(rstpc_n), .f(wbus));
`endif
  int checks = 0, errors = 0;
  logic [31:0] m_pc;
  bit m_boot, m_halt, m_mis;
  logic [31:0] m_hist[$];
  logic [7:0] wexp [5] = '{8'hF8, 8'hF8, 8'hFC, 8'h00, 8'h04};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkb(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic bit m_fv();
    return !m_boot && !m_halt && !bus.stall;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0;
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_mis = 1'b0;
    m_hist.delete();
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".pc_step"}, bus.pc_step, m_pc + 32'd4);
    chkb({tag, ".fetch_vld"}, bus.fetch_vld, m_fv());
    chkb({tag, ".misalign"}, bus.misalign, m_mis);
    chkb({tag, ".halted"}, bus.halted, m_halt);
`ifdef PC_HIST_EN
    for (int i = 0; i < 4; i++) begin
      bus.hist_rd_idx = 2'(i);
      #1 chk($sformatf("%s.hist%0d", tag, i), bus.hist_rd_pc,
             i < m_hist.size() ? m_hist[m_hist.size() - 1 - i] : 32'h0);
    end
`endif
  endtask

  // One clock of the reference model: spec priority exc > redirect > stall > sequential
  task automatic tick();
    logic [31:0] npc;
    bit nboot, nhalt, nmis;
    npc = m_pc; nboot = m_boot; nhalt = m_halt; nmis = 1'b0;
    if (m_boot) nboot = 1'b0;
    else if (bus.exc) begin
      npc = EXC;
      nhalt = 1'b0;
    end else begin
      if (bus.redirect) begin
        if (bus.redirect_tgt[1:0] != 2'b00) begin npc = EXC; nmis = 1'b1; end
        else npc = bus.redirect_tgt;
      end else if (!m_halt && !bus.stall) npc = m_pc + 32'd4;
      if (!m_halt && bus.halt_req) nhalt = 1'b1;
      else if (m_halt && bus.resume) nhalt = 1'b0;
    end
    if (m_fv()) begin
      m_hist.push_back(m_pc);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
    @(posedge clkpc);
    #1;
    m_pc = npc; m_boot = nboot; m_halt = nhalt; m_mis = nmis;
  endtask

  task automatic step(string tag, bit st, bit rd, logic [31:0] tgt, bit ex, bit hr, bit rs);
    bus.stall = st; bus.redirect = rd; bus.redirect_tgt = tgt;
    bus.exc = ex; bus.halt_req = hr; bus.resume = rs;
    #1 chk_all(tag);
    tick();
  endtask

  initial begin
    bus.stall = 0; bus.redirect = 0; bus.redirect_tgt = '0;
    bus.exc = 0; bus.halt_req = 0; bus.resume = 0;
    wbus.stall = 0; wbus.redirect = 0; wbus.redirect_tgt = '0;
    wbus.exc = 0; wbus.halt_req = 0; wbus.resume = 0;
`ifdef PC_HIST_EN
    bus.hist_rd_idx = '0; wbus.hist_rd_idx = '0;
`endif
    m_reset();
    #12 chk_all("reset");
    chk("reset.wrap_pc", 32'(wbus.pc), 32'hF8);
    #1 rstpc_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        chk("wrap.pc", 32'(wbus.pc), 32'(wexp[i]));
        chkb("wrap.fetch_vld", wbus.fetch_vld, i != 0);
        chkb("wrap.misalign", wbus.misalign, 1'b0);
      end
      chk("free.pc", bus.pc, i == 0 ? 32'h0 : 32'((i - 1) * 4));
      step("free", 0, 0, 0, 0, 0, 0);
    end
    step("to10", 0, 1, 32'h10, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 0, 0, 0, 0);
      chk("stall.pc", bus.pc, 32'h10);
      chkb("stall.fetch_vld", bus.fetch_vld, 1'b0);
    end
    step("stall_redir", 1, 1, 32'h200, 0, 0, 0);
    chk("stall_redir.pc", bus.pc, 32'h200);
    step("mis", 0, 1, 32'h203, 0, 0, 0);
    chk("mis.pc", bus.pc, 32'h80);
    chkb("mis.pulse", bus.misalign, 1'b1);
    step("mis_clr", 0, 0, 0, 0, 0, 0);
    chkb("mis.clear", bus.misalign, 1'b0);
    step("exc_all", 1, 1, 32'h400, 1, 0, 0);
    chk("exc_all.pc", bus.pc, 32'h80);
    step("to20", 0, 1, 32'h20, 0, 0, 0);
    step("halt", 0, 0, 0, 0, 1, 0);
    chk("halt.pc", bus.pc, 32'h24);
    chkb("halt.halted", bus.halted, 1'b1);
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 0, 0, 0, 0);
    chk("hold.pc", bus.pc, 32'h24);
    step("resume", 0, 0, 0, 0, 0, 1);
    chk("resume.pc", bus.pc, 32'h24);
    chkb("resume.fetch_vld", bus.fetch_vld, 1'b1);
    step("after_resume", 0, 0, 0, 0, 0, 0);
    chk("after_resume.pc", bus.pc, 32'h28);
    step("halt300", 0, 1, 32'h300, 0, 1, 0);
    step("h300", 0, 0, 0, 0, 0, 0);
    chk("h300.pc", bus.pc, 32'h300);
    chkb("h300.halted", bus.halted, 1'b1);
    #2 rstpc_n = 1'b0;
    #1;
    chk("async.pc", bus.pc, 32'h0);
    chkb("async.halted", bus.halted, 1'b0);
    chkb("async.fetch_vld", bus.fetch_vld, 1'b0);
    m_reset();
    chk_all("async");
    @(posedge clkpc);
    #2 rstpc_n = 1'b1;
    for (int i = 0; i < 8; i++) step("refill", 0, 0, 0, 0, 0, 0);
`ifdef PC_HIST_EN
    bus.hist_rd_idx = 2'd0;
    #1 chk("hist.idx0", bus.hist_rd_pc, 32'h18);
    bus.hist_rd_idx = 2'd1;
    #1 chk("hist.idx1", bus.hist_rd_pc, 32'h14);
    bus.hist_rd_idx = 2'd3;
    #1 chk("hist.idx3", bus.hist_rd_pc, 32'h0C);
`endif
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom_range(0, 32'hFFF);
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, tgt,
           $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
    end
    chk_all("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
